// File: rtl/gb_cpu_common_pkg.sv
// Shared CPU types: ALU opcodes, ALU instruction word and the CB executor's state/decode helpers.
package gb_cpu_common_pkg;

  typedef enum logic [4:0] {
    ALU_NOP           = 5'd0,
    ALU_ADD, ALU_ADC, ALU_SUB, ALU_SBC, ALU_AND, ALU_XOR, ALU_OR, ALU_CP,
    ALU_INC, ALU_DEC,
    ALU_ROTL, ALU_ROTR, ALU_ROTL_CARRY, ALU_ROTR_CARRY,
    ALU_SHIFT_L, ALU_SHIFT_R_ARITH, ALU_SWAP, ALU_SHIFT_R_LOGIC,
    ALU_BIT, ALU_RESET, ALU_SET
  } alu_opcode_t;

  typedef struct packed {
    alu_opcode_t opcode;
    logic [2:0]  dst_sel;
    logic [2:0]  src_sel;
    logic [7:0]  imm;
  } gb_instruction_t;

  typedef enum logic [2:0] {
    IDLE, EXEC_REG, MEM_RD, MEM_EXEC, MEM_WR
  } cb_state_t;

  localparam logic [1:0] CB_GRP_ROT    = 2'b00;
  localparam logic [1:0] CB_GRP_BIT    = 2'b01;
  localparam logic [1:0] CB_GRP_RES    = 2'b10;
  localparam logic [1:0] CB_GRP_SET    = 2'b11;
  localparam logic [2:0] CB_REG_HL_IND = 3'd6;

  function automatic alu_opcode_t cb_rot_opcode(input logic [2:0] y);
    case (y)
      3'd0:    return ALU_ROTL;
      3'd1:    return ALU_ROTR;
      3'd2:    return ALU_ROTL_CARRY;
      3'd3:    return ALU_ROTR_CARRY;
      3'd4:    return ALU_SHIFT_L;
      3'd5:    return ALU_SHIFT_R_ARITH;
      3'd6:    return ALU_SWAP;
      default: return ALU_SHIFT_R_LOGIC;
    endcase
  endfunction

endpackage

// File: rtl/gb_cpu_cb_executor.sv
// Sequences CB-prefixed ops through the external ALU: register forms retire one cycle after accept,
// (HL) forms read-modify-write memory and stall on mem_rvalid/mem_wack; cb_ready is low while busy.
module gb_cpu_cb_executor
  import gb_cpu_common_pkg::*;
#(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cb_valid,
  input  logic [7:0]        cb_opcode,
  output logic              cb_ready,
  output logic              done,
  output logic [2:0]        rf_rd_sel,
  input  logic [7:0]        rf_rd_data,
  output logic              rf_we,
  output logic [2:0]        rf_wr_sel,
  output logic [7:0]        rf_wr_data,
  input  logic [ADDR_W-1:0] hl,
  input  logic [3:0]        flags_in,
  output logic              flags_we,
  output logic [3:0]        flags_out,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_re,
  input  logic [7:0]        mem_rdata,
  input  logic              mem_rvalid,
  output logic              mem_we,
  output logic [7:0]        mem_wdata,
  input  logic              mem_wack,
  output gb_instruction_t   alu_instr,
  output logic [7:0]        alu_in0,
  output logic [7:0]        alu_in1,
  output logic              alu_carry_in,
  input  logic [7:0]        alu_out,
  input  logic              alu_z,
  input  logic              alu_n,
  input  logic              alu_h,
  input  logic              alu_c
);

  cb_state_t         r_state;
  logic [7:0]        r_opcode;
  logic [ADDR_W-1:0] r_addr;
  logic [7:0]        r_operand;
  logic [7:0]        r_wdata;

  logic [1:0]  w_grp;
  logic [2:0]  w_y;
  logic [2:0]  w_reg;
  logic        w_is_bit;
  logic        w_flags_en;
  logic [3:0]  w_flags;
  alu_opcode_t w_alu_op;
  logic        w_unused_flags;

  assign w_grp          = r_opcode[7:6];
  assign w_y            = r_opcode[5:3];
  assign w_reg          = r_opcode[2:0];
  assign w_is_bit       = (w_grp == CB_GRP_BIT);
  assign w_flags_en     = (w_grp == CB_GRP_ROT) || w_is_bit;
  // BIT leaves C untouched and forces N=0, H=1
  assign w_flags        = w_is_bit ? {alu_z, 1'b0, 1'b1, flags_in[0]}
                                   : {alu_z, alu_n, alu_h, alu_c};
  assign w_unused_flags = &{1'b0, flags_in[3:1]};

  always_comb begin
    case (w_grp)
      CB_GRP_ROT: w_alu_op = cb_rot_opcode(w_y);
      CB_GRP_BIT: w_alu_op = ALU_BIT;
      CB_GRP_RES: w_alu_op = ALU_RESET;
      default:    w_alu_op = ALU_SET;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_opcode  <= '0;
      r_addr    <= '0;
      r_operand <= '0;
      r_wdata   <= '0;
    end else begin
      case (r_state)
        IDLE: if (cb_valid) begin
          r_opcode <= cb_opcode;
          if (cb_opcode[2:0] == CB_REG_HL_IND) begin
            r_addr  <= hl;
            r_state <= MEM_RD;
          end else begin
            r_state <= EXEC_REG;
          end
        end
        EXEC_REG: r_state <= IDLE;
        MEM_RD: if (mem_rvalid) begin
          r_operand <= mem_rdata;
          r_state   <= MEM_EXEC;
        end
        MEM_EXEC: if (w_is_bit) begin
          r_state <= IDLE;
        end else begin
          r_wdata <= alu_out;
          r_state <= MEM_WR;
        end
        MEM_WR:  if (mem_wack) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  always_comb begin
    cb_ready     = 1'b0;
    done         = 1'b0;
    rf_rd_sel    = '0;
    rf_we        = 1'b0;
    rf_wr_sel    = '0;
    rf_wr_data   = '0;
    flags_we     = 1'b0;
    flags_out    = '0;
    mem_addr     = '0;
    mem_re       = 1'b0;
    mem_we       = 1'b0;
    mem_wdata    = '0;
    alu_instr    = '0;
    alu_in0      = '0;
    alu_in1      = '0;
    alu_carry_in = 1'b0;
    if (r_state != IDLE) begin
      alu_instr.opcode = w_alu_op;
      alu_in1          = (w_grp == CB_GRP_ROT) ? 8'h00 : {5'b0, w_y};
      alu_carry_in     = flags_in[0];
    end
    case (r_state)
      IDLE: cb_ready = 1'b1;
      EXEC_REG: begin
        rf_rd_sel  = w_reg;
        alu_in0    = rf_rd_data;
        rf_we      = !w_is_bit;
        rf_wr_sel  = w_reg;
        rf_wr_data = alu_out;
        flags_we   = w_flags_en;
        flags_out  = w_flags;
        done       = 1'b1;
      end
      MEM_RD: begin
        mem_addr = r_addr;
        mem_re   = 1'b1;
      end
      MEM_EXEC: begin
        mem_addr  = r_addr;
        alu_in0   = r_operand;
        flags_we  = w_flags_en;
        flags_out = w_flags;
        done      = w_is_bit;
      end
      MEM_WR: begin
        mem_addr  = r_addr;
        mem_we    = 1'b1;
        mem_wdata = r_wdata;
        done      = mem_wack;
      end
      default: ;
    endcase
    // state only returns to IDLE at the next edge, so mask strobes during the reset cycle itself
    if (reset) begin
      cb_ready = 1'b0;
      done     = 1'b0;
      rf_we    = 1'b0;
      flags_we = 1'b0;
      mem_re   = 1'b0;
      mem_we   = 1'b0;
    end
  end

endmodule

// File: tb/tb_gb_cpu_cb_executor.sv
// Directed bench for the CB executor with a behavioural ALU, register file and memory handshake.
module tb_gb_cpu_cb_executor;
  import gb_cpu_common_pkg::*;

  logic            clk = 1'b0;
  logic            reset;
  logic            cb_valid;
  logic [7:0]      cb_opcode;
  logic            cb_ready;
  logic            done;
  logic [2:0]      rf_rd_sel;
  logic [7:0]      rf_rd_data;
  logic            rf_we;
  logic [2:0]      rf_wr_sel;
  logic [7:0]      rf_wr_data;
  logic [15:0]     hl;
  logic [3:0]      flags_in;
  logic            flags_we;
  logic [3:0]      flags_out;
  logic [15:0]     mem_addr;
  logic            mem_re;
  logic [7:0]      mem_rdata;
  logic            mem_rvalid;
  logic            mem_we;
  logic [7:0]      mem_wdata;
  logic            mem_wack;
  gb_instruction_t alu_instr;
  logic [7:0]      alu_in0;
  logic [7:0]      alu_in1;
  logic            alu_carry_in;
  logic [7:0]      alu_out;
  logic            alu_z, alu_n, alu_h, alu_c;

  logic [7:0] regs [8];
  int total = 0;
  int bad   = 0;
  int n_re = 0, n_we = 0, n_fwe = 0, n_done = 0, n_both = 0;
  int snap_re, snap_we, snap_fwe, snap_done;

  always #5 clk = ~clk;

  gb_cpu_cb_executor #(.ADDR_W(16)) dut (
    .clk(clk), .reset(reset), .cb_valid(cb_valid), .cb_opcode(cb_opcode),
    .cb_ready(cb_ready), .done(done), .rf_rd_sel(rf_rd_sel), .rf_rd_data(rf_rd_data),
    .rf_we(rf_we), .rf_wr_sel(rf_wr_sel), .rf_wr_data(rf_wr_data), .hl(hl),
    .flags_in(flags_in), .flags_we(flags_we), .flags_out(flags_out),
    .mem_addr(mem_addr), .mem_re(mem_re), .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
    .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_wack(mem_wack),
    .alu_instr(alu_instr), .alu_in0(alu_in0), .alu_in1(alu_in1), .alu_carry_in(alu_carry_in),
    .alu_out(alu_out), .alu_z(alu_z), .alu_n(alu_n), .alu_h(alu_h), .alu_c(alu_c)
  );

  assign rf_rd_data = regs[rf_rd_sel];

  always_comb begin
    alu_out = alu_in0;
    alu_n   = 1'b0;
    alu_h   = 1'b0;
    alu_c   = 1'b0;
    case (alu_instr.opcode)
      ALU_ROTL:          begin alu_out = {alu_in0[6:0], alu_in0[7]};   alu_c = alu_in0[7]; end
      ALU_ROTR:          begin alu_out = {alu_in0[0], alu_in0[7:1]};   alu_c = alu_in0[0]; end
      ALU_ROTL_CARRY:    begin alu_out = {alu_in0[6:0], alu_carry_in}; alu_c = alu_in0[7]; end
      ALU_ROTR_CARRY:    begin alu_out = {alu_carry_in, alu_in0[7:1]}; alu_c = alu_in0[0]; end
      ALU_SHIFT_L:       begin alu_out = {alu_in0[6:0], 1'b0};         alu_c = alu_in0[7]; end
      ALU_SHIFT_R_ARITH: begin alu_out = {alu_in0[7], alu_in0[7:1]};   alu_c = alu_in0[0]; end
      ALU_SWAP:          alu_out = {alu_in0[3:0], alu_in0[7:4]};
      ALU_SHIFT_R_LOGIC: begin alu_out = {1'b0, alu_in0[7:1]};         alu_c = alu_in0[0]; end
      ALU_BIT:           alu_h = 1'b1;
      ALU_RESET:         alu_out = alu_in0 & ~(8'h01 << alu_in1[2:0]);
      ALU_SET:           alu_out = alu_in0 | (8'h01 << alu_in1[2:0]);
      default: ;
    endcase
    alu_z = (alu_instr.opcode == ALU_BIT) ? ~alu_in0[alu_in1[2:0]] : (alu_out == 8'h00);
  end

  always @(negedge clk) begin
    if (mem_re)           n_re++;
    if (mem_we)           n_we++;
    if (flags_we)         n_fwe++;
    if (done)             n_done++;
    if (mem_re && mem_we) n_both++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic snap();
    snap_re   = n_re;
    snap_we   = n_we;
    snap_fwe  = n_fwe;
    snap_done = n_done;
  endtask

  initial begin
    reset = 1'b1; cb_valid = 1'b0; cb_opcode = 8'h00; hl = 16'h0000; flags_in = 4'h0;
    mem_rdata = 8'h00; mem_rvalid = 1'b0; mem_wack = 1'b0;
    for (int i = 0; i < 8; i++) regs[i] = 8'h00;
    next_cyc(); next_cyc();
    @(negedge clk);
    check_eq("rst_ready", 32'(cb_ready), 32'h0);
    check_eq("rst_strobes", 32'({rf_we, flags_we, mem_re, mem_we, done}), 32'h0);
    next_cyc();
    reset = 1'b0;
    @(negedge clk);
    check_eq("ready_after_rst", 32'(cb_ready), 32'h1);

    // RLC B
    regs[0] = 8'h85; flags_in = 4'b0000; cb_opcode = 8'h00; cb_valid = 1'b1;
    next_cyc();
    cb_valid = 1'b0; snap();
    @(negedge clk);
    check_eq("rlc_done", 32'(done), 32'h1);
    check_eq("rlc_rf_we", 32'(rf_we), 32'h1);
    check_eq("rlc_sel", 32'(rf_wr_sel), 32'h0);
    check_eq("rlc_data", 32'(rf_wr_data), 32'h0B);
    check_eq("rlc_fwe", 32'(flags_we), 32'h1);
    check_eq("rlc_flags", 32'(flags_out), 32'h1);
    check_eq("rlc_busy", 32'(cb_ready), 32'h0);
    next_cyc();
    @(negedge clk);
    check_eq("rlc_done_pulse", 32'(done), 32'h0);
    check_eq("rlc_no_mem", 32'((n_re - snap_re) + (n_we - snap_we)), 32'h0);

    // BIT 7,H keeps C
    regs[4] = 8'h00; flags_in = 4'b0001; cb_opcode = 8'h7C; cb_valid = 1'b1;
    next_cyc();
    cb_valid = 1'b0;
    @(negedge clk);
    check_eq("bit_done", 32'(done), 32'h1);
    check_eq("bit_rf_we", 32'(rf_we), 32'h0);
    check_eq("bit_op", 32'(alu_instr.opcode), 32'(ALU_BIT));
    check_eq("bit_in1", 32'(alu_in1), 32'h07);
    check_eq("bit_flags", 32'({flags_we, flags_out}), 32'h1B);
    next_cyc();

    // SET 0,(HL) with 3 read wait cycles and HL changing mid-flight
    hl = 16'hC000; flags_in = 4'b0000; cb_opcode = 8'hC6; cb_valid = 1'b1;
    next_cyc();
    cb_valid = 1'b0; hl = 16'h1234; snap();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("set_rd_wait", 32'({mem_re, mem_we, done, cb_ready}), 32'h8);
      check_eq("set_rd_addr", 32'(mem_addr), 32'hC000);
      next_cyc();
    end
    mem_rvalid = 1'b1; mem_rdata = 8'hF0;
    next_cyc();
    mem_rvalid = 1'b0; mem_rdata = 8'h00;
    @(negedge clk);
    check_eq("set_exec", 32'({mem_re, mem_we, done}), 32'h0);
    check_eq("set_in0", 32'(alu_in0), 32'hF0);
    next_cyc();
    @(negedge clk);
    check_eq("set_wr", 32'({mem_re, mem_we, done}), 32'h2);
    check_eq("set_wr_addr", 32'(mem_addr), 32'hC000);
    check_eq("set_wdata", 32'(mem_wdata), 32'hF1);
    next_cyc();
    mem_wack = 1'b1;
    @(negedge clk);
    check_eq("set_wack_done", 32'({mem_we, done}), 32'h3);
    check_eq("set_wdata_hold", 32'(mem_wdata), 32'hF1);
    next_cyc();
    mem_wack = 1'b0;
    @(negedge clk);
    check_eq("set_idle", 32'({cb_ready, mem_we}), 32'h2);
    check_eq("set_no_fwe", 32'(n_fwe - snap_fwe), 32'h0);
    check_eq("set_one_done", 32'(n_done - snap_done), 32'h1);

    // SWAP (HL), data 0x00
    hl = 16'h8000; flags_in = 4'b0001; cb_opcode = 8'h36; cb_valid = 1'b1;
    next_cyc();
    cb_valid = 1'b0; mem_rvalid = 1'b1; mem_rdata = 8'h00;
    next_cyc();
    mem_rvalid = 1'b0;
    @(negedge clk);
    check_eq("swap_flags", 32'({flags_we, flags_out}), 32'h18);
    check_eq("swap_exec_done", 32'(done), 32'h0);
    next_cyc();
    mem_wack = 1'b1;
    @(negedge clk);
    check_eq("swap_wr", 32'({mem_we, done}), 32'h3);
    check_eq("swap_wdata", 32'(mem_wdata), 32'h00);
    check_eq("swap_addr", 32'(mem_addr), 32'h8000);
    next_cyc();
    mem_wack = 1'b0;

    // BIT 0,(HL): retires in MEM_EXEC, no memory write
    flags_in = 4'b1001; cb_opcode = 8'h46; cb_valid = 1'b1;
    next_cyc();
    cb_valid = 1'b0; mem_rvalid = 1'b1; mem_rdata = 8'h01; snap();
    next_cyc();
    mem_rvalid = 1'b0;
    @(negedge clk);
    check_eq("bithl_done", 32'(done), 32'h1);
    check_eq("bithl_flags", 32'({flags_we, flags_out}), 32'h13);
    next_cyc();
    @(negedge clk);
    check_eq("bithl_idle", 32'(cb_ready), 32'h1);
    check_eq("bithl_no_we", 32'(n_we - snap_we), 32'h0);

    // back-to-back with cb_valid held: RLC B then RL C
    regs[0] = 8'h0B; regs[1] = 8'h80; flags_in = 4'b0000; cb_opcode = 8'h00; cb_valid = 1'b1;
    next_cyc();
    cb_opcode = 8'h11;
    @(negedge clk);
    check_eq("b2b_first", 32'({done, cb_ready, rf_wr_sel, rf_wr_data}), 32'({2'b10, 3'd0, 8'h16}));
    check_eq("b2b_first_flags", 32'(flags_out), 32'h0);
    next_cyc();
    @(negedge clk);
    check_eq("b2b_gap", 32'({done, cb_ready}), 32'h1);
    next_cyc();
    cb_valid = 1'b0;
    @(negedge clk);
    check_eq("b2b_second", 32'({done, cb_ready, rf_wr_sel, rf_wr_data}), 32'({2'b10, 3'd1, 8'h00}));
    check_eq("b2b_second_flags", 32'(flags_out), 32'h9);
    next_cyc();

    // reset while a memory write is pending
    hl = 16'h9000; flags_in = 4'b0000; cb_opcode = 8'hC6; cb_valid = 1'b1;
    next_cyc();
    cb_valid = 1'b0; mem_rvalid = 1'b1; mem_rdata = 8'h00;
    next_cyc();
    mem_rvalid = 1'b0;
    next_cyc();
    @(negedge clk);
    check_eq("rstwr_pending", 32'({mem_we, mem_wdata}), 32'h101);
    next_cyc();
    reset = 1'b1; snap();
    @(negedge clk);
    check_eq("rstwr_abort", 32'({mem_we, done, cb_ready}), 32'h0);
    next_cyc();
    reset = 1'b0;
    @(negedge clk);
    check_eq("rstwr_ready", 32'({cb_ready, mem_we}), 32'h2);
    check_eq("rstwr_no_done", 32'(n_done - snap_done), 32'h0);

    // RR C after reset
    regs[1] = 8'h01; flags_in = 4'b0001; cb_opcode = 8'h19; cb_valid = 1'b1;
    next_cyc();
    cb_valid = 1'b0;
    @(negedge clk);
    check_eq("rr_cin", 32'(alu_carry_in), 32'h1);
    check_eq("rr_wr", 32'({done, rf_we, rf_wr_sel, rf_wr_data}), 32'({2'b11, 3'd1, 8'h80}));
    check_eq("rr_flags", 32'({flags_we, flags_out}), 32'h11);
    next_cyc();
    check_eq("re_we_exclusive", 32'(n_both), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
